// File: rtl/regfile_dump_pkg.sv
// Shared defaults and FSM state encoding for the regfile dump engine.
// RF_WIDTH/RF_DEPTH must match the register file they read from.
package regfile_dump_pkg;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_AW    = $clog2(RF_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready stream of {index, value} pairs from the dump engine.
// master: valid/index/data out, ready in. slave: the reverse.
interface regfile_dump_if
    import regfile_dump_pkg::*;
#(
    parameter int AW    = RF_AW,
    parameter int WIDTH = RF_WIDTH
);

    logic             valid;
    logic             ready;
    logic [AW-1:0]    index;
    logic [WIDTH-1:0] data;

    modport master (output valid, index, data, input ready);
    modport slave  (input valid, index, data, output ready);

endinterface

// File: rtl/regfile_dump.sv
// Walks first_reg..last_reg through a spare async regfile read port and
// streams {index, value} over out. Ports: clk, rst (sync, active-high),
// start/first_reg/last_reg/abort control, rd_addr/rd_data read port,
// out stream (master), busy/done/range_err status.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    first_reg,
    input  logic [AW-1:0]    last_reg,
    input  logic             abort,
    output logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    regfile_dump_if.master   out,
    output logic             busy,
    output logic             done,
    output logic             range_err
);

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    last_q, last_d;
    logic             valid_q, valid_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             rerr_q, rerr_d;
    logic             hs;

    assign hs = valid_q && out.ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        data_d  = data_q;
        rerr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (first_reg <= last_reg) begin
                        last_d  = last_reg;
                        addr_d  = first_reg;
                        state_d = FETCH;
                    end else begin
                        rerr_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    data_d  = rd_data;
                    idx_d   = addr_q;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // A handshake coinciding with abort is still delivered;
                // both simply drop valid and leave.
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (hs) begin
                    valid_d = 1'b0;
                    // Compare before incrementing so last=DEPTH-1 never wraps.
                    if (addr_q == last_q) begin
                        state_d = FINISH;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = FETCH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            rerr_q  <= rerr_d;
        end
    end

    // addr_q only moves on entry to FETCH, so it doubles as a held rd_addr.
    assign rd_addr   = addr_q;
    assign out.valid = valid_q;
    assign out.index = idx_q;
    assign out.data  = data_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign range_err = rerr_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized self-checking bench for regfile_dump against a
// range/array reference model of the expected pair stream.
module tb_regfile_dump;

    localparam int AW = 5;
    localparam int W  = 32;
    localparam int D  = 32;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [AW-1:0] first_reg, last_reg, rd_addr;
    logic [W-1:0]  rd_data;
    logic          busy, done, range_err;
    logic [W-1:0]  regs [D];

    int total = 0;
    int bad   = 0;

    int           got_idx [$];
    logic [W-1:0] got_dat [$];
    int done_at, done_cnt, last_hs, rerr_cnt, busy_cnt;
    int valid_cnt, unstable, first_valid;

    regfile_dump_if #(.AW(AW), .WIDTH(W)) ob ();

    regfile_dump #(.WIDTH(W), .DEPTH(D), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out       (ob),
        .busy      (busy),
        .done      (done),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    assign rd_data = regs[rd_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_regs();
        for (int i = 0; i < D; i++) regs[i] = $urandom;
    endtask

    // Drives one start and records what the sink sees; cycle 0 = start cycle.
    task automatic collect(input int first, input int last, input int stall,
                           input int budget, input int busy_start_at);
        int cnt;
        int wait_n;
        bit pend;
        logic [AW-1:0] pi;
        logic [W-1:0]  pd;
        got_idx.delete();
        got_dat.delete();
        done_at = -1; done_cnt = 0; last_hs = -1; rerr_cnt = 0;
        busy_cnt = 0; valid_cnt = 0; unstable = 0; first_valid = -1;
        wait_n = 0; pend = 0; pi = '0; pd = '0;
        first_reg = AW'(first);
        last_reg  = AW'(last);
        start     = 1'b1;
        ob.ready  = (stall == 0);
        tick();
        cnt = 1;
        while (cnt < budget) begin
            if (cnt == busy_start_at) begin
                start = 1'b1; first_reg = '0; last_reg = AW'(1);
            end else begin
                start = 1'b0;
            end
            if (range_err) rerr_cnt++;
            if (busy) busy_cnt++;
            if (done) begin done_at = cnt; done_cnt++; end
            if (ob.valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cnt;
                if (pend && (ob.index !== pi || ob.data !== pd)) unstable++;
                if (wait_n < stall) begin
                    ob.ready = 1'b0; wait_n++; pend = 1'b1;
                    pi = ob.index; pd = ob.data;
                end else begin
                    ob.ready = 1'b1;
                    got_idx.push_back(int'(ob.index));
                    got_dat.push_back(ob.data);
                    last_hs = cnt; wait_n = 0; pend = 1'b0;
                end
            end else begin
                ob.ready = (stall == 0);
            end
            if (done_at >= 0 && cnt >= done_at + 2) break;
            tick();
            cnt++;
        end
        start = 1'b0;
        ob.ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        tick(); tick();
        start = 1'b0; abort = 1'b0;
        total += 7;
        if (rd_addr !== '0) begin bad++; $display("FAIL rst_rd_addr got=%0d exp=0", rd_addr); end
        if (ob.valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ob.valid); end
        if (ob.index !== '0) begin bad++; $display("FAIL rst_index got=%0d exp=0", ob.index); end
        if (ob.data !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", ob.data); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        if (range_err !== 1'b0) begin bad++; $display("FAIL rst_rerr got=%b exp=0", range_err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < D; i++) regs[i] = 32'hA500_0000 + i;
        collect(0, 31, 0, 200, -1);
        total++;
        if (got_idx.size() != 32) begin bad++; $display("FAIL full_count got=%0d exp=32", got_idx.size()); end
        for (int i = 0; i < got_idx.size() && i < 32; i++) begin
            total++;
            if (got_idx[i] != i || got_dat[i] !== 32'hA500_0000 + i) begin
                bad++;
                $display("FAIL full_pair[%0d] got=%0d/%h exp=%0d/%h", i, got_idx[i], got_dat[i], i, 32'hA500_0000 + i);
            end
        end
        total += 3;
        if (first_valid != 2) begin bad++; $display("FAIL full_first_valid got=%0d exp=2", first_valid); end
        if (done_at != 65) begin bad++; $display("FAIL full_done_cycle got=%0d exp=65", done_at); end
        if (done_cnt != 1) begin bad++; $display("FAIL full_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_single_and_range();
        rand_regs();
        collect(5, 5, 0, 20, -1);
        total += 3;
        if (got_idx.size() != 1) begin bad++; $display("FAIL single_count got=%0d exp=1", got_idx.size()); end
        else if (got_idx[0] != 5 || got_dat[0] !== regs[5]) begin
            bad++; $display("FAIL single_pair got=%0d/%h exp=5/%h", got_idx[0], got_dat[0], regs[5]);
        end
        if (done_at != last_hs + 1 || done_at != 3) begin
            bad++; $display("FAIL single_done got=%0d exp=3 (hs=%0d)", done_at, last_hs);
        end
        collect(7, 3, 0, 6, -1);
        total += 3;
        if (rerr_cnt != 1) begin bad++; $display("FAIL range_err_pulses got=%0d exp=1", rerr_cnt); end
        if (busy_cnt != 0) begin bad++; $display("FAIL range_busy got=%0d exp=0", busy_cnt); end
        if (valid_cnt != 0 || done_cnt != 0) begin
            bad++; $display("FAIL range_no_out got=%0d/%0d exp=0/0", valid_cnt, done_cnt);
        end
    endtask

    task automatic test_stall();
        rand_regs();
        collect(0, 3, 4, 100, -1);
        total++;
        if (got_idx.size() != 4) begin bad++; $display("FAIL stall_count got=%0d exp=4", got_idx.size()); end
        for (int i = 0; i < got_idx.size() && i < 4; i++) begin
            total++;
            if (got_idx[i] != i || got_dat[i] !== regs[i]) begin
                bad++; $display("FAIL stall_pair[%0d] got=%0d/%h exp=%0d/%h", i, got_idx[i], got_dat[i], i, regs[i]);
            end
        end
        total += 3;
        if (unstable != 0) begin bad++; $display("FAIL stall_stable got=%0d exp=0", unstable); end
        if (valid_cnt != 20) begin bad++; $display("FAIL stall_valid_cycles got=%0d exp=20", valid_cnt); end
        if (done_at != last_hs + 1 || done_at != 25) begin
            bad++; $display("FAIL stall_done got=%0d exp=25", done_at);
        end
    endtask

    task automatic test_abort();
        int hs;
        bit hit;
        int late;
        int f, l;
        rand_regs();
        hs = 0; hit = 1'b0; late = 0;
        first_reg = '0; last_reg = AW'(7); ob.ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 20 && !hit; c++) begin
            if (ob.valid) begin
                if (hs == 2) begin
                    ob.ready = 1'b0; abort = 1'b1; hit = 1'b1;
                end else begin
                    hs++;
                end
            end
            if (!hit) tick();
        end
        total++;
        if (!hit) begin bad++; $display("FAIL abort_reach_third got=%0d exp=2", hs); end
        tick();
        abort = 1'b0; ob.ready = 1'b1;
        total += 2;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b exp=0", busy); end
        if (ob.valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b exp=0", ob.valid); end
        for (int c = 0; c < 4; c++) begin
            if (done || ob.valid) late++;
            tick();
        end
        total++;
        if (late != 0) begin bad++; $display("FAIL abort_quiet got=%0d exp=0", late); end
        f = $urandom_range(0, 20);
        l = $urandom_range(f, 31);
        collect(f, l, 0, 100, -1);
        total++;
        if (got_idx.size() != l - f + 1) begin
            bad++; $display("FAIL abort_restart_count got=%0d exp=%0d", got_idx.size(), l - f + 1);
        end
        for (int i = 0; i < got_idx.size() && i <= l - f; i++) begin
            total++;
            if (got_idx[i] != f + i || got_dat[i] !== regs[f + i]) begin
                bad++; $display("FAIL abort_restart[%0d] got=%0d/%h exp=%0d/%h", i, got_idx[i], got_dat[i], f + i, regs[f + i]);
            end
        end
    endtask

    task automatic test_top();
        rand_regs();
        collect(28, 31, 0, 40, -1);
        total++;
        if (got_idx.size() != 4) begin bad++; $display("FAIL top_count got=%0d exp=4", got_idx.size()); end
        for (int i = 0; i < got_idx.size() && i < 4; i++) begin
            total++;
            if (got_idx[i] != 28 + i || got_dat[i] !== regs[28 + i]) begin
                bad++; $display("FAIL top_pair[%0d] got=%0d/%h exp=%0d/%h", i, got_idx[i], got_dat[i], 28 + i, regs[28 + i]);
            end
        end
        total += 3;
        if (done_at != 9 || done_cnt != 1) begin
            bad++; $display("FAIL top_done got=%0d/%0d exp=9/1", done_at, done_cnt);
        end
        if (rd_addr !== AW'(31)) begin bad++; $display("FAIL top_rd_addr_hold got=%0d exp=31", rd_addr); end
        if (busy !== 1'b0) begin bad++; $display("FAIL top_idle got=%b exp=0", busy); end
    endtask

    task automatic test_busy_start_and_rst();
        rand_regs();
        collect(10, 20, 0, 60, 5);
        total += 2;
        if (got_idx.size() != 11) begin bad++; $display("FAIL busy_start_count got=%0d exp=11", got_idx.size()); end
        for (int i = 0; i < got_idx.size() && i < 11; i++) begin
            total++;
            if (got_idx[i] != 10 + i || got_dat[i] !== regs[10 + i]) begin
                bad++; $display("FAIL busy_start_pair[%0d] got=%0d/%h exp=%0d", i, got_idx[i], got_dat[i], 10 + i);
            end
        end
        if (done_cnt != 1) begin bad++; $display("FAIL busy_start_done got=%0d exp=1", done_cnt); end
        first_reg = '0; last_reg = AW'(31); start = 1'b1; ob.ready = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        total += 4;
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        if (ob.valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", ob.valid); end
        if (ob.index !== '0 || ob.data !== '0) begin
            bad++; $display("FAIL mid_rst_pair got=%0d/%h exp=0/0", ob.index, ob.data);
        end
        if (rd_addr !== '0) begin bad++; $display("FAIL mid_rst_rd_addr got=%0d exp=0", rd_addr); end
        rst = 1'b0; ob.ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int f, l, s, n;
            rand_regs();
            f = $urandom_range(0, 31);
            l = $urandom_range(f, 31);
            s = $urandom_range(0, 3);
            n = l - f + 1;
            collect(f, l, s, n * (s + 2) + 10, -1);
            total += 3;
            if (got_idx.size() != n) begin
                bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, got_idx.size(), n);
            end
            for (int i = 0; i < got_idx.size() && i < n; i++) begin
                total++;
                if (got_idx[i] != f + i || got_dat[i] !== regs[f + i]) begin
                    bad++; $display("FAIL rnd%0d_pair[%0d] got=%0d/%h exp=%0d/%h", it, i, got_idx[i], got_dat[i], f + i, regs[f + i]);
                end
            end
            if (done_at != n * (s + 2) + 1 || done_cnt != 1) begin
                bad++; $display("FAIL rnd%0d_done got=%0d/%0d exp=%0d/1", it, done_at, done_cnt, n * (s + 2) + 1);
            end
            if (unstable != 0) begin bad++; $display("FAIL rnd%0d_stable got=%0d exp=0", it, unstable); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        first_reg = '0; last_reg = '0; ob.ready = 1'b1;
        for (int i = 0; i < D; i++) regs[i] = '0;
        test_reset();
        test_full();
        test_single_and_range();
        test_stall();
        test_abort();
        test_top();
        test_busy_start_and_rst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
